// File: rtl/riscv_rf_wb_arbiter.sv
// rtl/riscv_rf_wb_arbiter.sv - round-robin arbiter sharing two register-file write ports
// Optional feature macro: RF_WB_ARB_PERF_EN (adds stall_cnt_o stall counter)
module riscv_rf_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic                          we_b_o,
  output logic                          busy_o
`ifdef RF_WB_ARB_PERF_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_nxt;
  logic [PTR_W-1:0]      idx_a;
  logic [PTR_W-1:0]      idx_b;
  logic                  gnt_a;
  logic                  gnt_b;
  logic [ADDR_WIDTH-1:0] addr_a_sel;
  int                    scan_idx;
  int                    last_idx;

  // Round-robin scan from rr_ptr: x0 writes are acknowledged and dropped, first real
  // request takes port A, next one with a different address takes port B.
  always_comb begin
    req_ready_o = '0;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    idx_a       = '0;
    idx_b       = '0;
    addr_a_sel  = '0;
    scan_idx    = 0;
    if (!rst && !flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (req_valid_i[scan_idx]) begin
          if (req_addr_i[scan_idx*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
            req_ready_o[scan_idx] = 1'b1;
          end else if (!gnt_a) begin
            gnt_a                 = 1'b1;
            idx_a                 = PTR_W'(scan_idx);
            addr_a_sel            = req_addr_i[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
            req_ready_o[scan_idx] = 1'b1;
          end else if (!gnt_b &&
                       req_addr_i[scan_idx*ADDR_WIDTH +: ADDR_WIDTH] != addr_a_sel) begin
            gnt_b                 = 1'b1;
            idx_b                 = PTR_W'(scan_idx);
            req_ready_o[scan_idx] = 1'b1;
          end
        end
      end
    end
  end

  // Pointer advances past the last port grant; x0 drops and idle cycles leave it alone.
  always_comb begin
    last_idx = gnt_b ? int'(idx_b) : int'(idx_a);
    last_idx = last_idx + 1;
    if (last_idx >= NUM_REQ) last_idx = 0;
    rr_nxt = (gnt_a || gnt_b) ? PTR_W'(last_idx) : rr_ptr;
  end

  // Registered port drive: grants of cycle N write the register file in cycle N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      we_a_o    <= 1'b0;
      we_b_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      we_a_o <= gnt_a;
      we_b_o <= gnt_b;
      if (gnt_a) begin
        waddr_a_o <= addr_a_sel;
        wdata_a_o <= req_data_i[int'(idx_a)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (gnt_b) begin
        waddr_b_o <= req_addr_i[int'(idx_b)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_b_o <= req_data_i[int'(idx_b)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy_o = we_a_o | we_b_o;

`ifdef RF_WB_ARB_PERF_EN
  logic stall_any;

  // A stall is a real (non-x0) valid request left unacknowledged in an unflushed cycle.
  always_comb begin
    stall_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_i[i] && !req_ready_o[i] &&
          req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)
        stall_any = 1'b1;
    end
    if (flush_i) stall_any = 1'b0;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (stall_any && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
